// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and parity mode constants for the UART transmitter
package uart_pkg;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a show-ahead head word
// ports: clk, rst (sync, active-high), wr/din enqueue, rd dequeue, dout = head word, full/empty flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic push, pop;
    assign push  = wr && !full;
    assign pop   = rd && !empty;
    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign dout  = mem[rp];
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter, one bit per clk_en tick
// ports: clk, rst (sync, active-high), data_input/wr_en enqueue, clk_en bit tick,
//        tx serial line (idle high), tx_busy, fifo_full, fifo_empty, overflow (rejected write pulse)
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_input,
    input  logic                 wr_en,
    input  logic                 clk_en,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 overflow
);
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("DATA_BITS must be 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
        $error("PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    state_t state, next_state;
    logic [DATA_BITS-1:0] head, shifter;
    logic [3:0] cnt, next_cnt;
    logic par_bit, tx_d, fifo_pop, last_data, last_stop;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr_en),
        .rd    (fifo_pop),
        .din   (data_input),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign last_data = cnt == 4'(DATA_BITS - 1);
    assign last_stop = cnt == 4'(STOP_BITS - 1);
    // pop from idle, or on the tick ending the final stop bit so frames run back to back
    assign fifo_pop  = clk_en && !fifo_empty && (state == S_IDLE || (state == S_STOP && last_stop));
    assign tx_busy   = state != S_IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            tx       <= 1'b1;
            overflow <= 1'b0;
            shifter  <= '0;
            par_bit  <= 1'b0;
        end else begin
            overflow <= wr_en && fifo_full;
            if (clk_en) begin
                state   <= next_state;
                cnt     <= next_cnt;
                tx      <= tx_d;
                shifter <= fifo_pop ? head : shifter >> 1;
                par_bit <= fifo_pop ? (^head) ^ (PARITY == PAR_ODD) : par_bit;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (!fifo_empty) next_state = S_START;
            S_START:  next_state = S_DATA;
            S_DATA:   if (last_data) next_state = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            S_PARITY: next_state = S_STOP;
            S_STOP:   if (last_stop) next_state = fifo_empty ? S_IDLE : S_START;
            default:  next_state = S_IDLE;
        endcase
    end

    // the line value is chosen by the state being entered; shifter[0] is always the next data bit
    always_comb begin
        next_cnt = (next_state != state) ? 4'd0 : cnt + 4'd1;
        tx_d     = next_state == S_START  ? 1'b0 :
                   next_state == S_DATA   ? shifter[0] :
                   next_state == S_PARITY ? par_bit : 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench driving four transmitter configurations (8N1, 8E1, 8O1, 7N2)
module tb_uart_tx_fifo;
    typedef struct {
        int at;
        int inst;
        logic [4:0] m;
        logic [4:0] v;
        string nm;
    } chk_t;

    localparam int FL [4] = '{10, 11, 11, 10};
    localparam logic [4:0] ALL   = 5'b11111;
    localparam logic [4:0] IDLEV = 5'b10010;
    localparam logic [4:0] BUSY  = 5'b01000;

    logic clk = 1'b0;
    logic rst, clk_en, done;
    logic [3:0] wr;
    logic [7:0] din;
    logic [3:0] tx_w, busy_w, full_w, empty_w, ovf_w;
    logic ce_q = 1'b0, rst_q = 1'b1, done_seen = 1'b0;
    int cyc = 0;
    int vectors = 0, errors = 0;
    logic [15:0] exp_q [4][$];
    chk_t st_q[$];
    logic [3:0] coll = '0, bb = '0;
    int idx [4];
    logic [15:0] bits [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int DB  = g == 3 ? 7 : 8;
        localparam int PAR = g == 1 ? 2 : g == 2 ? 1 : 0;
        localparam int SB  = g == 3 ? 2 : 1;
        uart_tx_fifo #(.DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(4)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .data_input (din[DB-1:0]),
            .wr_en      (wr[g]),
            .clk_en     (clk_en),
            .tx         (tx_w[g]),
            .tx_busy    (busy_w[g]),
            .fifo_full  (full_w[g]),
            .fifo_empty (empty_w[g]),
            .overflow   (ovf_w[g])
        );
    end

    always @(posedge clk) begin
        ce_q  <= clk_en;
        rst_q <= rst;
        cyc   <= cyc + 1;
    end

    task automatic chk(input int dly, input int inst, input logic [4:0] m, input logic [4:0] v, input string nm);
        st_q.push_back('{cyc + dly, inst, m, v, nm});
    endtask

    always @(negedge clk) begin
        logic [15:0] e;
        logic [4:0] got;
        for (int i = 0; i < 4; i++) begin
            if (rst_q) coll[i] = 1'b0;
            else if (ce_q) begin
                if (!coll[i]) begin
                    if (!tx_w[i]) begin
                        coll[i] = 1'b1;
                        idx[i]  = 1;
                        bits[i] = '0;
                        bb[i]   = !busy_w[i];
                    end
                end else begin
                    bits[i][idx[i]] = tx_w[i];
                    bb[i] = bb[i] | !busy_w[i];
                    idx[i]++;
                    if (idx[i] == FL[i]) begin
                        coll[i] = 1'b0;
                        vectors++;
                        if (exp_q[i].size() == 0) begin
                            errors++;
                            $display("FAIL frame[%0d] unexpected frame got %h required none", i, bits[i]);
                        end else begin
                            e = exp_q[i].pop_front();
                            if (bits[i] != e || bb[i]) begin
                                errors++;
                                $display("FAIL frame[%0d] got %h busy_drop=%0b required %h busy_drop=0", i, bits[i], bb[i], e);
                            end
                        end
                    end
                end
            end
        end
        for (int k = st_q.size() - 1; k >= 0; k--) begin
            if (st_q[k].at == cyc) begin
                got = {tx_w[st_q[k].inst], busy_w[st_q[k].inst], full_w[st_q[k].inst],
                       empty_w[st_q[k].inst], ovf_w[st_q[k].inst]};
                vectors++;
                if ((got & st_q[k].m) != (st_q[k].v & st_q[k].m)) begin
                    errors++;
                    $display("FAIL %s[%0d] cyc %0d {tx,busy,full,empty,ovf} got %b required %b mask %b",
                             st_q[k].nm, st_q[k].inst, cyc, got, st_q[k].v, st_q[k].m);
                end
                st_q.delete(k);
            end
        end
        if (done && !done_seen) begin
            done_seen = 1'b1;
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (exp_q[i].size() != 0) begin
                    errors++;
                    $display("FAIL pending[%0d] frames never seen got %0d required 0", i, exp_q[i].size());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; clk_en = 1'b0; wr = '0; din = '0; done = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk(1, i, ALL, IDLEV, "reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        // 8N1 single frame 0x61
        @(negedge clk);
        clk_en = 1'b1; din = 8'h61; wr = 4'b0001;
        exp_q[0].push_back({1'b1, 8'h61, 1'b0});
        chk(1, 0, 5'b01010, 5'b00000, "stored");
        chk(2, 0, BUSY, BUSY, "busy_first");
        chk(11, 0, BUSY, BUSY, "busy_last");
        chk(12, 0, ALL, IDLEV, "done_8n1");
        @(negedge clk);
        wr = '0;
        repeat (14) @(negedge clk);
        // even and odd parity on 0x61, then 7N2 on 0x7F
        din = 8'h61; wr = 4'b0110;
        exp_q[1].push_back({1'b1, 1'b1, 8'h61, 1'b0});
        exp_q[2].push_back({1'b1, 1'b0, 8'h61, 1'b0});
        @(negedge clk);
        din = 8'h7F; wr = 4'b1000;
        exp_q[3].push_back({1'b1, 1'b1, 7'h7F, 1'b0});
        @(negedge clk);
        wr = '0;
        repeat (14) @(negedge clk);
        for (int i = 1; i < 4; i++) chk(1, i, ALL, IDLEV, "idle_par");
        // back-to-back frames
        @(negedge clk);
        din = 8'h11; wr = 4'b0001;
        exp_q[0].push_back({1'b1, 8'h11, 1'b0});
        exp_q[0].push_back({1'b1, 8'h22, 1'b0});
        exp_q[0].push_back({1'b1, 8'h33, 1'b0});
        for (int k = 2; k < 32; k++) chk(k, 0, BUSY, BUSY, "b2b_busy");
        chk(32, 0, ALL, IDLEV, "b2b_done");
        @(negedge clk);
        din = 8'h22;
        @(negedge clk);
        din = 8'h33;
        @(negedge clk);
        wr = '0;
        repeat (32) @(negedge clk);
        // fill with clk_en held low, two rejected writes
        clk_en = 1'b0; din = 8'hA1; wr = 4'b0001;
        chk(3, 0, 5'b00100, 5'b00000, "not_full3");
        chk(4, 0, 5'b00101, 5'b00100, "full4");
        chk(5, 0, 5'b00101, 5'b00101, "ovf1");
        chk(6, 0, 5'b00101, 5'b00101, "ovf2");
        chk(7, 0, 5'b00101, 5'b00100, "ovf_end");
        exp_q[0].push_back({1'b1, 8'hA1, 1'b0});
        exp_q[0].push_back({1'b1, 8'hA2, 1'b0});
        exp_q[0].push_back({1'b1, 8'hA3, 1'b0});
        exp_q[0].push_back({1'b1, 8'hA4, 1'b0});
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            din = 8'hA1 + 8'(k);
        end
        @(negedge clk);
        wr = '0;
        @(negedge clk);
        @(negedge clk);
        clk_en = 1'b1;
        repeat (45) @(negedge clk);
        chk(1, 0, ALL, IDLEV, "drain_done");
        // reset during data bit 3, with a second word buffered
        @(negedge clk);
        din = 8'h61; wr = 4'b0001;
        exp_q[0].push_back({1'b1, 8'h61, 1'b0});
        exp_q[0].push_back({1'b1, 8'h62, 1'b0});
        @(negedge clk);
        din = 8'h62;
        @(negedge clk);
        wr = '0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        exp_q[0].delete();
        chk(1, 0, ALL, IDLEV, "rst_abort");
        @(negedge clk);
        rst = 1'b0; din = 8'h55; wr = 4'b0001;
        exp_q[0].push_back({1'b1, 8'h55, 1'b0});
        @(negedge clk);
        wr = '0;
        repeat (14) @(negedge clk);
        chk(1, 0, ALL, IDLEV, "after_rst");
        repeat (2) @(negedge clk);
        done = 1'b1;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter PARITY, default 0, parity mode (0 none, 1 odd, 2 even).
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, transmit buffer words (power of 2, >=2).
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port data_input  input  DATA_BITS  word to enqueue.
REQ-008 SHALL have port wr_en  input  1  enqueue strobe, one word per clk cycle high.
REQ-009 SHALL have port clk_en  input  1  bit-rate tick; one tick = one bit period.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port tx_busy  output  1  high while a frame is on the line.
REQ-012 SHALL have port fifo_full  output  1  buffer holds FIFO_DEPTH words.
REQ-013 SHALL have port fifo_empty  output  1  buffer holds zero words.
REQ-014 SHALL have port overflow  output  1  one-cycle pulse on a rejected write.

Function
REQ-015 wr_en=1 with fifo_full=0 SHALL store data_input; count updates next cycle.
REQ-016 wr_en=1 with fifo_full=1 SHALL drop the word and pulse overflow next cycle, even if a pop occurs in the same cycle.
REQ-017 Simultaneous accepted write and pop SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; transitions occur only on cycles with clk_en=1.
REQ-019 IDLE with fifo_empty=0 on a clk_en tick: pop head into shifter, tx<=0, go START.
REQ-020 START on tick: tx<=bit0, go DATA; DATA sends LSB first, one bit per tick, DATA_BITS ticks total.
REQ-021 After last data bit: go PARITY if PARITY!=0 (tx<=odd/even parity of word), else STOP.
REQ-022 STOP SHALL hold tx=1 for STOP_BITS ticks.
REQ-023 Tick ending the last stop bit: if fifo_empty=0, pop and enter START directly (no idle gap); else go IDLE.
REQ-024 Frame length SHALL be exactly 1+DATA_BITS+(PARITY!=0)+STOP_BITS ticks.
REQ-025 tx_busy SHALL equal (state!=IDLE); stays high across back-to-back frames.
REQ-026 tx SHALL be registered, glitch-free, and change only on clk_en cycles or reset.
REQ-027 Writes SHALL never alter the word already loaded in the shifter.

Reset
REQ-028 rst=1 SHALL, on the next clk edge: tx=1, tx_busy=0, overflow=0, fifo_empty=1, fifo_full=0, state IDLE.
REQ-029 rst mid-frame SHALL abort the frame and discard all buffered words; rst overrides wr_en and clk_en.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state encoding and parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN).
REQ-031 Buffer SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; flags full/empty).
REQ-032 Illegal parameter values SHALL be rejected at elaboration.

Verification
REQ-033 8N1, write 0x61, clk_en every cycle -> tx = 0,1,0,0,0,0,1,1,0,1 then idle 1; tx_busy high 10 ticks.
REQ-034 PARITY=2, write 0x61 -> parity bit 1; PARITY=1 -> parity bit 0; frame 11 ticks.
REQ-035 Write 0x11,0x22,0x33 consecutive cycles -> three frames, no idle tick between, tx_busy never drops, then fifo_empty=1.
REQ-036 DEPTH 4, clk_en held 0, write 6 words -> fifo_full after 4th, overflow pulses twice, first 4 words sent in order once clk_en resumes.
REQ-037 rst during data bit 3 of 0x61 -> next cycle tx=1, tx_busy=0, fifo_empty=1; subsequent write 0x55 transmits cleanly.
REQ-038 DATA_BITS=7, STOP_BITS=2, write 0x7F -> 0, seven 1s, 1, 1 (10 ticks).
